// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: instruction codes, register IDs,
// status codes and the E pipeline register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0001;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0100;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    srcA:  RNONE,
    srcB:  RNONE,
    dstE:  RNONE,
    dstM:  RNONE,
    valA:  64'd0,
    valB:  64'd0,
    valC:  64'd0
  };

endpackage

// File: rtl/decode_if.sv
// D-to-E pipeline register bundle: the D register fields consumed by decode
// and the E register fields it produces.
interface decode_if;

  logic [3:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;

  logic [3:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [3:0]  E_srcA;
  logic [3:0]  E_srcB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [63:0] E_valC;

  modport master (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM,
           E_valA, E_valB, E_valC
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM,
           E_valA, E_valB, E_valC
  );

endinterface

// File: rtl/decode_regfile.sv
// Y86-64 register file: 15 x 64-bit, two combinational read ports,
// two write ports (M port wins on a same-register collision), async clear.
module regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_srcA,
  input  logic [3:0]  i_srcB,
  output logic [63:0] o_rdA,
  output logic [63:0] o_rdB,
  input  logic [3:0]  i_dstE,
  input  logic [63:0] i_valE,
  input  logic [3:0]  i_dstM,
  input  logic [63:0] i_valM
);

  logic [63:0] r_regs [0:14];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= 64'd0;
    end else begin
      if (i_dstE != RNONE) r_regs[i_dstE] <= i_valE;
      // Written second so the memory result wins when both target one register
      if (i_dstM != RNONE) r_regs[i_dstM] <= i_valM;
    end
  end

  assign o_rdA = (i_srcA == RNONE) ? 64'd0 : r_regs[i_srcA];
  assign o_rdB = (i_srcB == RNONE) ? 64'd0 : r_regs[i_srcB];

endmodule

// File: rtl/decode.sv
// Y86-64 decode/writeback stage: register ID decode, forwarding of valA/valB
// from e/M/W, register file ownership and the E pipeline register.
module decode
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  decode_if.slave     pif,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic        E_bubble,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB
);

  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_rdA;
  logic [63:0] w_rdB;
  logic [63:0] w_valA;
  logic [63:0] w_valB;
  e_reg_t      w_e_next;
  e_reg_t      r_e;

  // Youngest producer first; W paths also cover a same-cycle regfile write.
  function automatic logic [63:0] fwd(
    input logic [3:0]  src,
    input logic [63:0] rf,
    input logic [3:0]  ed,  input logic [63:0] ev,
    input logic [3:0]  mdm, input logic [63:0] mvm,
    input logic [3:0]  mde, input logic [63:0] mve,
    input logic [3:0]  wdm, input logic [63:0] wvm,
    input logic [3:0]  wde, input logic [63:0] wve
  );
    if (src == RNONE)    return rf;
    else if (src == ed)  return ev;
    else if (src == mdm) return mvm;
    else if (src == mde) return mve;
    else if (src == wdm) return wvm;
    else if (src == wde) return wve;
    else                 return rf;
  endfunction

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;

    case (pif.D_icode)
      I_CMOV, I_RMMOV, I_OP, I_PUSH: d_srcA = pif.D_rA;
      I_POP, I_RET:                  d_srcA = RSP;
      default:                       d_srcA = RNONE;
    endcase

    case (pif.D_icode)
      I_OP, I_RMMOV, I_MRMOV:        d_srcB = pif.D_rB;
      I_PUSH, I_POP, I_CALL, I_RET:  d_srcB = RSP;
      default:                       d_srcB = RNONE;
    endcase

    case (pif.D_icode)
      I_CMOV, I_IRMOV, I_OP:         w_dstE = pif.D_rB;
      I_PUSH, I_POP, I_CALL, I_RET:  w_dstE = RSP;
      default:                       w_dstE = RNONE;
    endcase

    case (pif.D_icode)
      I_MRMOV, I_POP:                w_dstM = pif.D_rA;
      default:                       w_dstM = RNONE;
    endcase
  end

  regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_srcA (d_srcA),
    .i_srcB (d_srcB),
    .o_rdA  (w_rdA),
    .o_rdB  (w_rdB),
    .i_dstE (W_dstE),
    .i_valE (W_valE),
    .i_dstM (W_dstM),
    .i_valM (W_valM)
  );

  always_comb begin
    if (pif.D_icode == I_CALL || pif.D_icode == I_JXX)
      w_valA = pif.D_valP;
    else
      w_valA = fwd(d_srcA, w_rdA, e_dstE, e_valE, M_dstM, m_valM,
                   M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    w_valB = fwd(d_srcB, w_rdB, e_dstE, e_valE, M_dstM, m_valM,
                 M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
  end

  always_comb begin
    w_e_next       = E_BUBBLE;
    w_e_next.stat  = pif.D_stat;
    w_e_next.icode = pif.D_icode;
    w_e_next.ifun  = pif.D_ifun;
    w_e_next.srcA  = d_srcA;
    w_e_next.srcB  = d_srcB;
    w_e_next.dstE  = w_dstE;
    w_e_next.dstM  = w_dstM;
    w_e_next.valA  = w_valA;
    w_e_next.valB  = w_valB;
    w_e_next.valC  = pif.D_valC;
  end

  // D -> E pipeline register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_e <= E_BUBBLE;
    else if (E_bubble) r_e <= E_BUBBLE;
    else               r_e <= w_e_next;
  end

  assign pif.E_stat  = r_e.stat;
  assign pif.E_icode = r_e.icode;
  assign pif.E_ifun  = r_e.ifun;
  assign pif.E_srcA  = r_e.srcA;
  assign pif.E_srcB  = r_e.srcB;
  assign pif.E_dstE  = r_e.dstE;
  assign pif.E_dstM  = r_e.dstM;
  assign pif.E_valA  = r_e.valA;
  assign pif.E_valB  = r_e.valB;
  assign pif.E_valC  = r_e.valC;

endmodule

// File: tb/tb_decode.sv
// Directed scoreboard bench for the Y86-64 decode stage.
module tb_decode;
  import y86_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_bubble;
  logic [3:0]  d_srcA, d_srcB;

  int passed = 0;
  int total  = 0;
  e_reg_t sb[$];

  decode_if pif ();

  decode dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pif      (pif),
    .e_dstE   (e_dstE),
    .e_valE   (e_valE),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM),
    .M_valE   (M_valE),
    .m_valM   (m_valM),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM),
    .W_valE   (W_valE),
    .W_valM   (W_valM),
    .E_bubble (E_bubble),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic e_reg_t mk(input logic [3:0] stat, icode, ifun, srcA, srcB, dstE, dstM,
                                input logic [63:0] valA, valB, valC);
    e_reg_t e;
    e = '{stat:stat, icode:icode, ifun:ifun, srcA:srcA, srcB:srcB, dstE:dstE, dstM:dstM,
          valA:valA, valB:valB, valC:valC};
    return e;
  endfunction

  task automatic cmp_e(input string tag);
    e_reg_t x;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
      return;
    end
    x = sb.pop_front();
    chk({tag, ".stat"},  pif.E_stat,  x.stat);
    chk({tag, ".icode"}, pif.E_icode, x.icode);
    chk({tag, ".ifun"},  pif.E_ifun,  x.ifun);
    chk({tag, ".srcA"},  pif.E_srcA,  x.srcA);
    chk({tag, ".srcB"},  pif.E_srcB,  x.srcB);
    chk({tag, ".dstE"},  pif.E_dstE,  x.dstE);
    chk({tag, ".dstM"},  pif.E_dstM,  x.dstM);
    chk({tag, ".valA"},  pif.E_valA,  x.valA);
    chk({tag, ".valB"},  pif.E_valB,  x.valB);
    chk({tag, ".valC"},  pif.E_valC,  x.valC);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    cmp_e(tag);
  endtask

  task automatic drive_d(input logic [3:0] stat, icode, ifun, rA, rB,
                         input logic [63:0] valC, valP);
    pif.D_stat  = stat;
    pif.D_icode = icode;
    pif.D_ifun  = ifun;
    pif.D_rA    = rA;
    pif.D_rB    = rB;
    pif.D_valC  = valC;
    pif.D_valP  = valP;
  endtask

  task automatic quiet();
    e_dstE = RNONE; e_valE = 64'd0;
    M_dstE = RNONE; M_valE = 64'd0;
    M_dstM = RNONE; m_valM = 64'd0;
    W_dstE = RNONE; W_valE = 64'd0;
    W_dstM = RNONE; W_valM = 64'd0;
    E_bubble = 1'b0;
  endtask

  initial begin
    quiet();
    drive_d(STAT_AOK, I_NOP, 4'h0, RNONE, RNONE, 64'd0, 64'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(E_BUBBLE);
    cmp_e("reset_async");

    // Reset dominates a valid D at a clock edge
    drive_d(STAT_AOK, I_IRMOV, 4'h0, RNONE, 4'h2, 64'd100, 64'd10);
    sb.push_back(E_BUBBLE);
    step("reset_hold");
    rst_n = 1'b1;

    // irmovq $100, %rdx
    drive_d(STAT_AOK, I_IRMOV, 4'h0, RNONE, 4'h2, 64'd100, 64'd10);
    #1;
    chk("irmov.d_srcA", d_srcA, RNONE);
    chk("irmov.d_srcB", d_srcB, RNONE);
    sb.push_back(mk(STAT_AOK, I_IRMOV, 4'h0, RNONE, RNONE, 4'h2, RNONE, 0, 0, 64'd100));
    step("irmov");

    // Write R3=55, then read it back
    drive_d(STAT_AOK, I_NOP, 4'h0, RNONE, RNONE, 64'd0, 64'd0);
    W_dstE = 4'h3; W_valE = 64'd55;
    sb.push_back(E_BUBBLE);
    step("wr_r3");
    quiet();
    drive_d(STAT_AOK, I_OP, 4'h0, 4'h3, 4'h3, 64'd0, 64'd0);
    #1;
    chk("op33.d_srcA", d_srcA, 4'h3);
    chk("op33.d_srcB", d_srcB, 4'h3);
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h3, 4'h3, 4'h3, RNONE, 64'd55, 64'd55, 0));
    step("rd_r3");

    // Same-cycle write of R5 is seen through the W path
    drive_d(STAT_AOK, I_OP, 4'h1, 4'h5, 4'h5, 64'd0, 64'd0);
    W_dstE = 4'h5; W_valE = 64'd55;
    sb.push_back(mk(STAT_AOK, I_OP, 4'h1, 4'h5, 4'h5, 4'h5, RNONE, 64'd55, 64'd55, 0));
    step("same_cycle_r5");
    quiet();

    // Forwarding priority on R5
    drive_d(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h5, 64'd0, 64'd0);
    e_dstE = 4'h5; e_valE = 64'd7;
    M_dstE = 4'h5; M_valE = 64'd9;
    W_dstM = 4'h5; W_valM = 64'd11;
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h5, 4'h5, RNONE, 64'd7, 64'd7, 0));
    step("fwd_e");
    e_dstE = RNONE;
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h5, 4'h5, RNONE, 64'd9, 64'd9, 0));
    step("fwd_M_E");
    M_dstM = 4'h5; m_valM = 64'd13;
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h5, 4'h5, RNONE, 64'd13, 64'd13, 0));
    step("fwd_M_M");
    M_dstM = RNONE; M_dstE = RNONE;
    W_dstE = 4'h5; W_valE = 64'd12;
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h5, 4'h5, RNONE, 64'd11, 64'd11, 0));
    step("fwd_W_M");
    quiet();
    // R5 now holds W_valM from the collision write above
    drive_d(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h1, 64'd0, 64'd0);
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h5, 4'h1, 4'h1, RNONE, 64'd11, 64'd0, 0));
    step("rd_r5");

    // call: valA = valP; srcB RSP forwarded from e over W
    drive_d(STAT_AOK, I_CALL, 4'h0, RNONE, RNONE, 64'h100, 64'h40);
    e_dstE = RSP; e_valE = 64'h77;
    W_dstE = RSP; W_valE = 64'h1000;
    sb.push_back(mk(STAT_AOK, I_CALL, 4'h0, RNONE, RSP, RSP, RNONE, 64'h40, 64'h77, 64'h100));
    step("call");
    quiet();

    drive_d(STAT_AOK, I_JXX, 4'h3, RNONE, RNONE, 64'h200, 64'h80);
    sb.push_back(mk(STAT_AOK, I_JXX, 4'h3, RNONE, RNONE, RNONE, RNONE, 64'h80, 0, 64'h200));
    step("jxx");

    drive_d(STAT_AOK, I_POP, 4'h0, 4'h6, RNONE, 64'd0, 64'd0);
    #1;
    chk("pop.d_srcA", d_srcA, RSP);
    chk("pop.d_srcB", d_srcB, RSP);
    sb.push_back(mk(STAT_AOK, I_POP, 4'h0, RSP, RSP, RSP, 4'h6, 64'h1000, 64'h1000, 0));
    step("popq");

    drive_d(STAT_AOK, I_PUSH, 4'h0, 4'h7, RNONE, 64'd0, 64'd0);
    sb.push_back(mk(STAT_AOK, I_PUSH, 4'h0, 4'h7, RSP, RSP, RNONE, 0, 64'h1000, 0));
    step("pushq");

    drive_d(STAT_AOK, I_RET, 4'h0, RNONE, RNONE, 64'd0, 64'd0);
    sb.push_back(mk(STAT_AOK, I_RET, 4'h0, RSP, RSP, RSP, RNONE, 64'h1000, 64'h1000, 0));
    step("ret");

    drive_d(STAT_AOK, I_RMMOV, 4'h0, 4'h3, 4'h5, 64'h18, 64'd0);
    sb.push_back(mk(STAT_AOK, I_RMMOV, 4'h0, 4'h3, 4'h5, RNONE, RNONE, 64'd55, 64'd11, 64'h18));
    step("rmmov");

    drive_d(STAT_AOK, I_MRMOV, 4'h0, 4'h3, 4'h5, 64'h20, 64'd0);
    sb.push_back(mk(STAT_AOK, I_MRMOV, 4'h0, RNONE, 4'h5, RNONE, 4'h3, 0, 64'd11, 64'h20));
    step("mrmov");

    drive_d(STAT_AOK, I_CMOV, 4'h3, 4'h5, 4'h6, 64'd0, 64'd0);
    sb.push_back(mk(STAT_AOK, I_CMOV, 4'h3, 4'h5, RNONE, 4'h6, RNONE, 64'd11, 0, 0));
    step("cmov");

    drive_d(STAT_HLT, I_HALT, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    sb.push_back(mk(STAT_HLT, I_HALT, 4'h0, RNONE, RNONE, RNONE, RNONE, 0, 0, 0));
    step("halt");

    // Write collision on R6: M value wins
    drive_d(STAT_AOK, I_NOP, 4'h0, RNONE, RNONE, 64'd0, 64'd0);
    W_dstE = 4'h6; W_valE = 64'd1;
    W_dstM = 4'h6; W_valM = 64'd2;
    sb.push_back(E_BUBBLE);
    step("collide_wr");
    quiet();
    drive_d(STAT_AOK, I_OP, 4'h0, 4'h6, 4'h6, 64'd0, 64'd0);
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h6, 4'h6, 4'h6, RNONE, 64'd2, 64'd2, 0));
    step("collide_rd");

    // Bubble overrides D, but the regfile write still happens
    drive_d(STAT_AOK, I_IRMOV, 4'h0, RNONE, 4'h2, 64'd5, 64'd0);
    E_bubble = 1'b1;
    W_dstE = 4'h7; W_valE = 64'h33;
    sb.push_back(E_BUBBLE);
    step("bubble");
    quiet();
    drive_d(STAT_AOK, I_OP, 4'h0, 4'h7, 4'h7, 64'd0, 64'd0);
    sb.push_back(mk(STAT_AOK, I_OP, 4'h0, 4'h7, 4'h7, 4'h7, RNONE, 64'h33, 64'h33, 0));
    step("bubble_wr");

    // Reset mid-cycle discards the in-flight E contents and clears registers
    drive_d(STAT_ADR, I_IRMOV, 4'h0, RNONE, 4'h9, 64'd77, 64'd0);
    sb.push_back(mk(STAT_ADR, I_IRMOV, 4'h0, RNONE, RNONE, 4'h9, RNONE, 0, 0, 64'd77));
    step("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(E_BUBBLE);
    cmp_e("reset_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 15; r++) begin
      logic [3:0] id;
      id = 4'(r);
      drive_d(STAT_AOK, I_OP, 4'h0, id, id, 64'd0, 64'd0);
      sb.push_back(mk(STAT_AOK, I_OP, 4'h0, id, id, id, RNONE, 0, 0, 0));
      step($sformatf("clr_r%0d", r));
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
